// File: rtl/sm4_out_serializer.sv
// Buffers 128-bit SM4 result blocks in a small FIFO and streams them out as
// 32-bit words (MSW first) over a valid/ready handshake. Define SM4_SER_LAST_EN to add LAST_o.
module sm4_out_serializer #(
  parameter int DEPTH = 2
) (
  input  logic         CLK_i,
  input  logic         RST_N_i,
  input  logic [127:0] DAT_i,
  input  logic         DAT_VALID_i,
  output logic [31:0]  WORD_o,
  output logic         WORD_VALID_o,
  input  logic         WORD_READY_i,
  output logic         FULL_o,
  output logic         OVF_o
`ifdef SM4_SER_LAST_EN
  ,
  output logic         LAST_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_EMPTY,
    ST_SEND
  } state_t;

  logic [127:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       word_idx;
  state_t           state;

  logic xfer;
  logic pop;
  logic push;
  logic drop;

  assign xfer = WORD_VALID_o && WORD_READY_i;
  assign pop  = xfer && (word_idx == 2'd3);
  // A full FIFO still accepts a block when the head leaves in the same cycle.
  assign push = DAT_VALID_i && (!FULL_o || pop);
  assign drop = DAT_VALID_i && FULL_o && !pop;

  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // NOTE: the block storage has no reset; the pointers and count alone
  // decide which entries are meaningful, so clearing wide data buys nothing.
  always_ff @(posedge CLK_i) begin
    if (push) mem[wr_ptr] <= DAT_i;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state        <= ST_EMPTY;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      word_idx     <= 2'd0;
      WORD_VALID_o <= 1'b0;
      FULL_o       <= 1'b0;
      OVF_o        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_nxt;
      FULL_o <= (count_nxt == CNT_W'(DEPTH));
      if (drop) OVF_o <= 1'b1;

      case (state)
        ST_EMPTY: begin
          word_idx <= 2'd0;
          if (count_nxt != '0) begin
            state        <= ST_SEND;
            WORD_VALID_o <= 1'b1;
          end
        end
        ST_SEND: begin
          // Index wraps 3 -> 0 on the popping transfer, ready for the next head.
          if (xfer) word_idx <= word_idx + 2'd1;
          if (count_nxt == '0) begin
            state        <= ST_EMPTY;
            WORD_VALID_o <= 1'b0;
          end
        end
        default: begin
          state        <= ST_EMPTY;
          WORD_VALID_o <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    WORD_o = '0;
    if (WORD_VALID_o) begin
      case (word_idx)
        2'd0:    WORD_o = mem[rd_ptr][127:96];
        2'd1:    WORD_o = mem[rd_ptr][95:64];
        2'd2:    WORD_o = mem[rd_ptr][63:32];
        default: WORD_o = mem[rd_ptr][31:0];
      endcase
    end
  end

`ifdef SM4_SER_LAST_EN
  assign LAST_o = WORD_VALID_o && (word_idx == 2'd3);
`endif

endmodule

// File: tb/tb_sm4_out_serializer.sv
// Directed bench for sm4_out_serializer: a DEPTH=2 and a DEPTH=4 instance
// share stimulus; vector table for single blocks plus hand-written sequences.
module tb_sm4_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] dat = '0;
  logic         dv = 1'b0;
  logic         rdy = 1'b0;

  logic [31:0] word2, word4;
  logic        valid2, valid4, full2, full4, ovf2, ovf4;
`ifdef SM4_SER_LAST_EN
  logic        last2, last4;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sm4_out_serializer #(.DEPTH(2)) u_dut2 (
    .CLK_i(clk), .RST_N_i(rst_n), .DAT_i(dat), .DAT_VALID_i(dv),
    .WORD_o(word2), .WORD_VALID_o(valid2), .WORD_READY_i(rdy),
    .FULL_o(full2), .OVF_o(ovf2)
`ifdef SM4_SER_LAST_EN
    , .LAST_o(last2)
`endif
  );

  sm4_out_serializer #(.DEPTH(4)) u_dut4 (
    .CLK_i(clk), .RST_N_i(rst_n), .DAT_i(dat), .DAT_VALID_i(dv),
    .WORD_o(word4), .WORD_VALID_o(valid4), .WORD_READY_i(rdy),
    .FULL_o(full4), .OVF_o(ovf4)
`ifdef SM4_SER_LAST_EN
    , .LAST_o(last4)
`endif
  );

  typedef struct packed {
    logic [127:0]     blk;
    logic [0:3][31:0] w;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Assert reset, check outputs before any clock edge, release after posedge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    dv    = 1'b0;
    rdy   = 1'b0;
    #1;
    check1({tag, "_rst_valid2"}, valid2, 1'b0);
    check1({tag, "_rst_ovf2"}, ovf2, 1'b0);
    check1({tag, "_rst_full2"}, full2, 1'b0);
    check32({tag, "_rst_word2"}, word2, 32'h0);
    check1({tag, "_rst_valid4"}, valid4, 1'b0);
`ifdef SM4_SER_LAST_EN
    check1({tag, "_rst_last2"}, last2, 1'b0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Called just after a posedge; the block is captured at the next posedge.
  task automatic push_block(input logic [127:0] b);
    dv  = 1'b1;
    dat = b;
    @(posedge clk); #1;
    dv  = 1'b0;
  endtask

  // Expect the 4 words of b on u_dut2 on consecutive cycles (ready must be 1).
  task automatic expect_words(input string tag, input logic [127:0] b);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check1($sformatf("%s_valid%0d", tag, k), valid2, 1'b1);
      check32($sformatf("%s_word%0d", tag, k), word2, b[127-32*k -: 32]);
`ifdef SM4_SER_LAST_EN
      check1($sformatf("%s_last%0d", tag, k), last2, (k == 3));
`endif
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[4];

  initial begin
    logic [127:0] a, b, c, d, blk;
    logic [31:0]  sb[$];
    logic [31:0]  exp_w;
    int           pushed, got, extra;

    vecs[0] = '{blk: 128'h681EDF34D206965E86B3E94F536E4246,
                w: {32'h681EDF34, 32'hD206965E, 32'h86B3E94F, 32'h536E4246}};
    vecs[1] = '{blk: 128'h0123456789ABCDEFFEDCBA9876543210,
                w: {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210}};
    vecs[2] = '{blk: 128'hFFFFFFFF000000005A5A5A5AA5A5A5A5,
                w: {32'hFFFFFFFF, 32'h00000000, 32'h5A5A5A5A, 32'hA5A5A5A5}};
    vecs[3] = '{blk: 128'h0000000180000000DEADBEEFCAFEF00D,
                w: {32'h00000001, 32'h80000000, 32'hDEADBEEF, 32'hCAFEF00D}};

    do_reset("init");

    // Single blocks, ready=1: word 0 one cycle after the push, then 4 in a row.
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_block(vecs[i].blk);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check1($sformatf("vec%0d_valid%0d", i, k), valid2, 1'b1);
        check32($sformatf("vec%0d_word%0d", i, k), word2, vecs[i].w[k]);
`ifdef SM4_SER_LAST_EN
        check1($sformatf("vec%0d_last%0d", i, k), last2, (k == 3));
`endif
        @(posedge clk); #1;
      end
      @(negedge clk);
      check1($sformatf("vec%0d_idle", i), valid2, 1'b0);
      @(posedge clk); #1;
    end

    // Back-to-back blocks stream without a gap.
    a = vecs[1].blk;
    b = vecs[2].blk;
    dv = 1'b1; dat = a;
    @(posedge clk); #1;
    dat = b;
    @(posedge clk); #1;
    dv = 1'b0;
    // Word A0 was already transferred at the edge that captured B.
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check32($sformatf("b2b_a%0d", k), word2, a[127-32*k -: 32]);
      @(posedge clk); #1;
    end
    expect_words("b2b_b", b);
    @(negedge clk);
    check1("b2b_idle", valid2, 1'b0);

    // Back-pressure: word 0 held for 5 cycles, then drained in order.
    do_reset("bp");
    push_block(vecs[0].blk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check1($sformatf("bp_hold_valid%0d", k), valid2, 1'b1);
      check32($sformatf("bp_hold_word%0d", k), word2, 32'h681EDF34);
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    expect_words("bp", vecs[0].blk);
    @(negedge clk);
    check1("bp_idle", valid2, 1'b0);

    // Overflow at DEPTH=2: C dropped, OVF sticky, only A then B drain.
    do_reset("ovf");
    a = 128'hA0000000A1111111A2222222A3333333;
    b = 128'hB0000000B1111111B2222222B3333333;
    c = 128'hC0000000C1111111C2222222C3333333;
    push_block(a);
    @(negedge clk); check1("ovf_full_after_a", full2, 1'b0);
    @(posedge clk); #1;
    push_block(b);
    @(negedge clk); check1("ovf_full_after_b", full2, 1'b1);
    check1("ovf_flag_before_c", ovf2, 1'b0);
    @(posedge clk); #1;
    push_block(c);
    @(negedge clk); check1("ovf_flag_after_c", ovf2, 1'b1);
    check1("ovf_full_after_c", full2, 1'b1);
    @(posedge clk); #1;
    rdy = 1'b1;
    expect_words("ovf_a", a);
    expect_words("ovf_b", b);
    @(negedge clk);
    check1("ovf_idle", valid2, 1'b0);
    check1("ovf_sticky", ovf2, 1'b1);

    // Full FIFO, push D in the cycle A's word 3 transfers: D is accepted.
    do_reset("pp");
    d = 128'hD0000000D1111111D2222222D3333333;
    push_block(a);
    push_block(b);
    @(negedge clk); check1("pp_full", full2, 1'b1);
    @(posedge clk); #1;
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check32($sformatf("pp_a%0d", k), word2, a[127-32*k -: 32]);
      if (k == 3) begin
        dv  = 1'b1;
        dat = d;
      end
      @(posedge clk); #1;
    end
    dv = 1'b0;
    @(negedge clk);
    check1("pp_ovf", ovf2, 1'b0);
    check1("pp_full_after", full2, 1'b1);
    @(posedge clk); #1;
    // B0 transferred at the edge just passed; continue with B1..B3.
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check32($sformatf("pp_b%0d", k), word2, b[127-32*k -: 32]);
      @(posedge clk); #1;
    end
    expect_words("pp_d", d);
    @(negedge clk);
    check1("pp_idle", valid2, 1'b0);
    check1("pp_ovf_end", ovf2, 1'b0);

    // Wrap at DEPTH=4: 10 random blocks, random ready, scoreboard check.
    do_reset("wrap");
    pushed = 0;
    got    = 0;
    extra  = 0;
    for (int cyc = 0; cyc < 10 * 8 + 40; cyc++) begin
      // Ready is high at least every other cycle so the backlog stays bounded.
      rdy = (cyc % 2 == 1) || ($urandom_range(0, 1) == 1);
      if (cyc % 8 == 0 && pushed < 10) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        dv  = 1'b1;
        dat = blk;
        for (int k = 0; k < 4; k++) sb.push_back(blk[127-32*k -: 32]);
        pushed++;
      end else begin
        dv = 1'b0;
      end
      @(negedge clk);
      if (valid4 && rdy) begin
        if (sb.size() > 0) begin
          exp_w = sb.pop_front();
          check32($sformatf("wrap_word%0d", got), word4, exp_w);
          got++;
        end else begin
          extra++;
        end
      end
      @(posedge clk); #1;
    end
    dv = 1'b0;
    checkn("wrap_words_received", got, 40);
    checkn("wrap_extra_words", extra, 0);
    check1("wrap_ovf", ovf4, 1'b0);
    check1("wrap_idle", valid4, 1'b0);

    // Reset mid-block (with OVF set) clears everything; next block starts at word 0.
    do_reset("mid");
    push_block(a);
    push_block(b);
    push_block(c);
    rdy = 1'b1;
    @(negedge clk);
    check1("mid_ovf_set", ovf2, 1'b1);
    check32("mid_w0", word2, a[127:96]);
    @(posedge clk); #1;
    @(negedge clk);
    check32("mid_w1", word2, a[95:64]);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_valid", valid2, 1'b0);
    check1("mid_rst_ovf", ovf2, 1'b0);
    check1("mid_rst_full", full2, 1'b0);
    check32("mid_rst_word", word2, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check1("mid_post_idle", valid2, 1'b0);
    @(posedge clk); #1;
    push_block(d);
    expect_words("mid_d", d);
    @(negedge clk);
    check1("mid_end_idle", valid2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm4_out_serializer.md
SM4_OUT_SERIALIZER -- requirements
Module: sm4_out_serializer

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the FIFO depth in 128-bit blocks; legal values are 2, 4 and 8.
REQ-002 CLK_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST_N_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 DAT_i  input  128  SHALL carry the block from the upstream SM4 core's DAT_o.
REQ-005 DAT_VALID_i  input  1  SHALL qualify DAT_i, driven by the upstream DAT_READY_o; high for one cycle per block, no back-pressure.
REQ-006 WORD_o  output  32  SHALL carry the current output word.
REQ-007 WORD_VALID_o  output  1  SHALL indicate that WORD_o is valid.
REQ-008 WORD_READY_i  input  1  SHALL be the consumer ready; a word transfers in any cycle where WORD_VALID_o and WORD_READY_i are both high.
REQ-009 FULL_o  output  1  SHALL be high when the FIFO holds DEPTH blocks.
REQ-010 OVF_o  output  1  SHALL be a sticky flag indicating that at least one block was dropped.

Function
REQ-011 Storage SHALL be a DEPTH-entry circular FIFO of 128-bit registers with wrapping read/write pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-012 A block SHALL be pushed at the clock edge when DAT_VALID_i=1 and either FULL_o=0 or the head block's final word transfers in the same cycle (push and pop in one cycle).
REQ-013 When DAT_VALID_i=1, FULL_o=1 and no pop occurs, the block SHALL be discarded, FIFO contents SHALL be unchanged, and OVF_o SHALL be set from the next cycle until reset.
REQ-014 Word order within a block SHALL be MSW first: index 0 = DAT_i[127:96], 1 = [95:64], 2 = [63:32], 3 = [31:0].
REQ-015 A 2-bit word index SHALL select WORD_o combinationally from the head entry; WORD_o SHALL be stable while WORD_VALID_o=1 and WORD_READY_i=0.
REQ-016 Read-side FSM states: EMPTY (WORD_VALID_o=0) and SEND (WORD_VALID_o=1).
REQ-017 FSM transitions:
- EMPTY->SEND when the count becomes nonzero.
- SEND: each transfer increments the index.
- Transfer at index 3 pops the head and resets the index to 0; SEND->EMPTY if the count becomes 0, otherwise stay in SEND with no idle cycle.
REQ-018 Latency: a block pushed at edge N SHALL present word 0 with WORD_VALID_o=1 in the cycle after edge N (from an empty FIFO).
REQ-019 With WORD_READY_i held at 1, the block SHALL drain as 4 words on 4 consecutive cycles, and back-to-back blocks SHALL stream without gaps.
REQ-020 Simultaneous push at count=0 with no pop SHALL behave as REQ-018; count SHALL be unchanged on a simultaneous push and pop.
REQ-021 Pointers and count SHALL wrap modulo DEPTH without loss across at least 3*DEPTH blocks.

Reset
REQ-022 RST_N_i low SHALL immediately clear the pointers, count, word index, FSM (to EMPTY), OVF_o, WORD_VALID_o and FULL_o; WORD_o SHALL read 0.
REQ-023 Reset asserted mid-block SHALL discard any partially sent block and all queued blocks; after release the first word out SHALL be word 0 of the next pushed block.
REQ-024 Storage data registers need not be reset.

Configuration
REQ-025 Macro SM4_SER_LAST_EN defined: an extra output LAST_o (1 bit) SHALL be high exactly when WORD_VALID_o=1 and the index is 3; reset value 0.
REQ-026 Macro SM4_SER_LAST_EN undefined: port LAST_o and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Single block: push 681EDF34D206965E86B3E94F536E4246, ready=1 -> words 681EDF34, D206965E, 86B3E94F, 536E4246 on 4 consecutive cycles starting one cycle after the push; LAST_o (if enabled) high on 536E4246 only.
REQ-028 Back-pressure: ready=0 for 5 cycles after the push -> WORD_O stays 681EDF34 with valid=1; after ready rises, 4 words are delivered in order with none lost or repeated.
REQ-029 Overflow with DEPTH=2 and ready=0: push blocks A, B, C -> FULL_o=1 after B, C dropped, OVF_o=1; on drain, only A then B appear.
REQ-030 Full with simultaneous push/pop: FIFO full, push D in the cycle A's word 3 transfers -> D accepted, OVF_o stays 0; output is B then D.
REQ-031 Wrap: 10 random blocks with random ready (DEPTH=4), pushes spaced at least 4 cycles apart -> output matches a scoreboard, OVF_o=0.
REQ-032 Reset mid-block: assert RST_N_i after word 1 of a block -> valid=0 and OVF_o=0 immediately; the next push outputs its own word 0 first.
